// File: rtl/uart_tx_arbiter_if.sv
// Byte-source / consumer bundle around uart_tx_arbiter: N pull sources on one
// side, a single out/get/empty consumer plus grant status on the other.
interface uart_tx_arbiter_if #(
   parameter int N = 2
);
   localparam int GW = $clog2(N);

   logic [8*N-1:0] src_data;
   logic [N-1:0]   src_empty;
   logic [N-1:0]   src_get;
   logic [7:0]     out;
   logic           get;
   logic           empty;
   logic [GW-1:0]  grant;
   logic           locked;

   modport master (
      input  src_data, src_empty, get,
      output src_get, out, empty, grant, locked
   );

   modport slave (
      output src_data, src_empty, get,
      input  src_get, out, empty, grant, locked
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-atomic arbiter sharing one uart_tx byte consumer among
// N pull sources; a grant ends on EOL, a burst cap, or an empty-source timeout.
module uart_tx_arbiter #(
   parameter int         N         = 2,
   parameter logic [7:0] EOL       = 8'h0A,
   parameter bit         LOCK_EOL  = 1'b1,
   parameter int         MAX_BURST = 64,
   parameter int         TIMEOUT   = 255
) (
   input  logic              clock,
   input  logic              reset,
   uart_tx_arbiter_if.master bus
);
   localparam int GW = $clog2(N);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int IW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] rr_q, rr_d;
   logic [BW-1:0] burst_q, burst_d;
   logic [IW-1:0] idle_q, idle_d;

   logic [GW-1:0] sel;
   logic          found;
   logic          locked;
   logic          cur_empty;
   logic          accept;
   logic          rel;
   logic [7:0]    cur_byte;
   logic [N-1:0]  src_get;

   assign locked    = (state_q == LOCKED);
   assign cur_byte  = bus.src_data[int'(grant_q)*8 +: 8];
   assign cur_empty = bus.src_empty[grant_q];
   assign accept    = locked & bus.get & ~cur_empty;

   // First non-empty source at or after the round-robin pointer.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && !bus.src_empty[(int'(rr_q) + k) % N]) begin
            found = 1'b1;
            sel   = GW'((int'(rr_q) + k) % N);
         end
      end
   end

   always_comb begin
      src_get = '0;
      if (accept) src_get[grant_q] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      burst_d = burst_q;
      idle_d  = idle_q;
      rel     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = LOCKED;
               grant_d = sel;
               burst_d = '0;
               idle_d  = '0;
            end
         end
         LOCKED: begin
            if (accept) begin
               burst_d = burst_q + 1'b1;
               idle_d  = '0;
               rel     = !LOCK_EOL || (cur_byte == EOL) ||
                         (burst_q == BW'(MAX_BURST - 1));
            end else if (cur_empty) begin
               idle_d = idle_q + 1'b1;
               rel    = (idle_q == IW'(TIMEOUT - 1));
            end else begin
               idle_d = '0;
            end
            // Grant index is kept after release so grant shows the last owner.
            if (rel) begin
               state_d = IDLE;
               rr_d    = (int'(grant_q) == N - 1) ? '0 : grant_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         burst_q <= '0;
         idle_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         burst_q <= burst_d;
         idle_q  <= idle_d;
      end
   end

   assign bus.out     = cur_byte;
   assign bus.empty   = ~locked | cur_empty;
   assign bus.src_get = src_get;
   assign bus.grant   = grant_q;
   assign bus.locked  = locked;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: three instances (short timeout, burst cap
// of 4, per-byte release) each fed by small FIFO source models.
module tb_uart_tx_arbiter;
   logic clock;
   logic reset;
   logic model_clr;

   int n_cmp;
   int n_bad;

   uart_tx_arbiter_if #(.N(2)) ifa ();
   uart_tx_arbiter_if #(.N(2)) ifb ();
   uart_tx_arbiter_if #(.N(2)) ifc ();

   uart_tx_arbiter #(.N(2), .TIMEOUT(8)) dut_a (
      .clock(clock), .reset(reset), .bus(ifa));
   uart_tx_arbiter #(.N(2), .MAX_BURST(4)) dut_b (
      .clock(clock), .reset(reset), .bus(ifb));
   uart_tx_arbiter #(.N(2), .LOCK_EOL(1'b0)) dut_c (
      .clock(clock), .reset(reset), .bus(ifc));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Source FIFO models: [dut][source][slot]
   logic [7:0]  mem  [3][2][64];
   logic [5:0]  wp   [3][2];
   logic [5:0]  rp   [3][2];
   logic [1:0]  sget [3];
   logic [1:0]  semp [3];
   logic [15:0] sdat [3];

   assign sget[0] = ifa.src_get;
   assign sget[1] = ifb.src_get;
   assign sget[2] = ifc.src_get;
   assign ifa.src_empty = semp[0];
   assign ifb.src_empty = semp[1];
   assign ifc.src_empty = semp[2];
   assign ifa.src_data  = sdat[0];
   assign ifb.src_data  = sdat[1];
   assign ifc.src_data  = sdat[2];

   always_comb begin
      for (int d = 0; d < 3; d++) begin
         semp[d] = '0;
         sdat[d] = '0;
         for (int s = 0; s < 2; s++) begin
            semp[d][s]        = (rp[d][s] == wp[d][s]);
            sdat[d][8*s +: 8] = mem[d][s][rp[d][s]];
         end
      end
   end

   always @(posedge clock) begin
      for (int d = 0; d < 3; d++)
         for (int s = 0; s < 2; s++)
            if (model_clr) rp[d][s] <= '0;
            else if (sget[d][s]) rp[d][s] <= rp[d][s] + 6'd1;
   end

   // {empty, locked, src_get[1:0], grant}
   logic [4:0] ctlv [3];
   logic [7:0] outv [3];
   assign ctlv[0] = {ifa.empty, ifa.locked, ifa.src_get, ifa.grant};
   assign ctlv[1] = {ifb.empty, ifb.locked, ifb.src_get, ifb.grant};
   assign ctlv[2] = {ifc.empty, ifc.locked, ifc.src_get, ifc.grant};
   assign outv[0] = ifa.out;
   assign outv[1] = ifb.out;
   assign outv[2] = ifc.out;

   logic [7:0] hello [7];

   task automatic push(input int d, input int s, input logic [7:0] b);
      mem[d][s][wp[d][s]] = b;
      wp[d][s] = wp[d][s] + 6'd1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      #1;
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (ctlv[d] !== 5'b10000) begin
            n_bad++; $display("FAIL reset_ctl dut%0d: got %b want %b", d, ctlv[d], 5'b10000);
         end
         n_cmp++;
         if (outv[d] !== 8'h00) begin
            n_bad++; $display("FAIL reset_out dut%0d: got %h want %h", d, outv[d], 8'h00);
         end
      end
      @(negedge clock);
      reset = 1'b0;
      model_clr = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         #1;
         for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (ctlv[d] !== 5'b10000) begin
               n_bad++; $display("FAIL idle_ctl dut%0d c=%0d: got %b want %b", d, c, ctlv[d], 5'b10000);
            end
         end
      end
   endtask

   task automatic test_message();
      int sent;
      int pulses;
      sent = 0;
      pulses = 0;
      @(negedge clock);
      for (int i = 0; i < 7; i++) push(0, 0, hello[i]);
      ifa.get = 1'b0;
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b10000) begin
         n_bad++; $display("FAIL msg_arb: got %b want %b", ctlv[0], 5'b10000);
      end
      for (int cyc = 0; cyc < 60 && sent < 7; cyc++) begin
         @(negedge clock);
         ifa.get = (cyc % 4 == 0);
         #1;
         if (ifa.src_get[0]) pulses++;
         if (ifa.get) begin
            n_cmp++;
            if (ctlv[0] !== 5'b01010) begin
               n_bad++; $display("FAIL msg_ctl byte%0d: got %b want %b", sent, ctlv[0], 5'b01010);
            end
            n_cmp++;
            if (outv[0] !== hello[sent]) begin
               n_bad++; $display("FAIL msg_out byte%0d: got %h want %h", sent, outv[0], hello[sent]);
            end
            sent++;
         end else begin
            n_cmp++;
            if (ctlv[0] !== 5'b01000) begin
               n_bad++; $display("FAIL msg_hold cyc%0d: got %b want %b", cyc, ctlv[0], 5'b01000);
            end
         end
      end
      @(negedge clock);
      ifa.get = 1'b0;
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b10000) begin
         n_bad++; $display("FAIL msg_release: got %b want %b", ctlv[0], 5'b10000);
      end
      n_cmp++;
      if (pulses !== 7) begin
         n_bad++; $display("FAIL msg_pulses: got %0d want %0d", pulses, 7);
      end
   endtask

   task automatic test_round_robin();
      logic       g;
      logic [4:0] exp;
      logic [7:0] ch;
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
         ch = 8'h41 + 8'(k);
         push(0, 0, ch); push(0, 0, 8'h0A);
         push(0, 1, ch); push(0, 1, 8'h0A);
      end
      ifa.get = 1'b1;
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b10000) begin
         n_bad++; $display("FAIL rr_arb: got %b want %b", ctlv[0], 5'b10000);
      end
      for (int m = 0; m < 8; m++) begin
         g   = (m % 2 == 0);
         ch  = 8'h41 + 8'(m / 2);
         exp = {1'b0, 1'b1, (g ? 2'b10 : 2'b01), g};
         @(negedge clock);
         #1;
         n_cmp++;
         if (ctlv[0] !== exp || outv[0] !== ch) begin
            n_bad++; $display("FAIL rr_first m=%0d: got %b/%h want %b/%h", m, ctlv[0], outv[0], exp, ch);
         end
         @(negedge clock);
         #1;
         n_cmp++;
         if (ctlv[0] !== exp || outv[0] !== 8'h0A) begin
            n_bad++; $display("FAIL rr_eol m=%0d: got %b/%h want %b/%h", m, ctlv[0], outv[0], exp, 8'h0A);
         end
         @(negedge clock);
         #1;
         n_cmp++;
         if (ctlv[0] !== {4'b1000, g}) begin
            n_bad++; $display("FAIL rr_gap m=%0d: got %b want %b", m, ctlv[0], {4'b1000, g});
         end
      end
      ifa.get = 1'b0;
   endtask

   task automatic test_timeout();
      @(negedge clock);
      push(0, 0, 8'h41); push(0, 0, 8'h42);
      ifa.get = 1'b1;
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b10000) begin
         n_bad++; $display("FAIL to_idle_get: got %b want %b", ctlv[0], 5'b10000);
      end
      @(negedge clock);
      push(0, 1, 8'h58); push(0, 1, 8'h0A);
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b01010 || outv[0] !== 8'h41) begin
         n_bad++; $display("FAIL to_A: got %b/%h want %b/%h", ctlv[0], outv[0], 5'b01010, 8'h41);
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b01010 || outv[0] !== 8'h42) begin
         n_bad++; $display("FAIL to_B: got %b/%h want %b/%h", ctlv[0], outv[0], 5'b01010, 8'h42);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         #1;
         n_cmp++;
         if (ctlv[0] !== 5'b11000) begin
            n_bad++; $display("FAIL to_wait i=%0d: got %b want %b", i, ctlv[0], 5'b11000);
         end
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b10000) begin
         n_bad++; $display("FAIL to_release: got %b want %b", ctlv[0], 5'b10000);
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b01101 || outv[0] !== 8'h58) begin
         n_bad++; $display("FAIL to_next: got %b/%h want %b/%h", ctlv[0], outv[0], 5'b01101, 8'h58);
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b01101 || outv[0] !== 8'h0A) begin
         n_bad++; $display("FAIL to_next_eol: got %b/%h want %b/%h", ctlv[0], outv[0], 5'b01101, 8'h0A);
      end
      @(negedge clock);
      ifa.get = 1'b0;
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b10001) begin
         n_bad++; $display("FAIL to_done: got %b want %b", ctlv[0], 5'b10001);
      end
   endtask

   task automatic test_burst_cap();
      @(negedge clock);
      for (int i = 0; i < 10; i++) push(1, 1, 8'h30 + 8'(i));
      ifb.get = 1'b1;
      #1;
      n_cmp++;
      if (ctlv[1] !== 5'b10000) begin
         n_bad++; $display("FAIL burst_arb: got %b want %b", ctlv[1], 5'b10000);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (i == 0) begin push(1, 0, 8'h4B); push(1, 0, 8'h0A); end
         #1;
         n_cmp++;
         if (ctlv[1] !== 5'b01101 || outv[1] !== 8'h30 + 8'(i)) begin
            n_bad++; $display("FAIL burst_first i=%0d: got %b/%h want %b/%h", i, ctlv[1], outv[1], 5'b01101, 8'h30 + 8'(i));
         end
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if (ctlv[1] !== 5'b10001) begin
         n_bad++; $display("FAIL burst_release: got %b want %b", ctlv[1], 5'b10001);
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if (ctlv[1] !== 5'b01010 || outv[1] !== 8'h4B) begin
         n_bad++; $display("FAIL burst_other: got %b/%h want %b/%h", ctlv[1], outv[1], 5'b01010, 8'h4B);
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if (ctlv[1] !== 5'b01010 || outv[1] !== 8'h0A) begin
         n_bad++; $display("FAIL burst_other_eol: got %b/%h want %b/%h", ctlv[1], outv[1], 5'b01010, 8'h0A);
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if (ctlv[1] !== 5'b10000) begin
         n_bad++; $display("FAIL burst_gap: got %b want %b", ctlv[1], 5'b10000);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         #1;
         n_cmp++;
         if (ctlv[1] !== 5'b01101 || outv[1] !== 8'h34 + 8'(i)) begin
            n_bad++; $display("FAIL burst_resume i=%0d: got %b/%h want %b/%h", i, ctlv[1], outv[1], 5'b01101, 8'h34 + 8'(i));
         end
      end
      @(negedge clock);
      ifb.get = 1'b0;
      #1;
      n_cmp++;
      if (ctlv[1] !== 5'b10001) begin
         n_bad++; $display("FAIL burst_release2: got %b want %b", ctlv[1], 5'b10001);
      end
   endtask

   task automatic test_lock_eol_off();
      logic [7:0] seq [4];
      logic       g;
      logic [4:0] exp;
      seq = '{8'h61, 8'h63, 8'h62, 8'h64};
      @(negedge clock);
      push(2, 0, 8'h61); push(2, 0, 8'h62);
      push(2, 1, 8'h63); push(2, 1, 8'h64);
      ifc.get = 1'b1;
      #1;
      n_cmp++;
      if (ctlv[2] !== 5'b10000) begin
         n_bad++; $display("FAIL noeol_arb: got %b want %b", ctlv[2], 5'b10000);
      end
      for (int m = 0; m < 4; m++) begin
         g   = (m % 2 == 1);
         exp = {1'b0, 1'b1, (g ? 2'b10 : 2'b01), g};
         @(negedge clock);
         #1;
         n_cmp++;
         if (ctlv[2] !== exp || outv[2] !== seq[m]) begin
            n_bad++; $display("FAIL noeol_byte m=%0d: got %b/%h want %b/%h", m, ctlv[2], outv[2], exp, seq[m]);
         end
         @(negedge clock);
         #1;
         n_cmp++;
         if (ctlv[2] !== {4'b1000, g}) begin
            n_bad++; $display("FAIL noeol_gap m=%0d: got %b want %b", m, ctlv[2], {4'b1000, g});
         end
      end
      ifc.get = 1'b0;
   endtask

   task automatic test_reset_mid();
      // One short message from source 0 moves the pointer to 1 first.
      @(negedge clock);
      push(0, 0, 8'h5A); push(0, 0, 8'h0A);
      ifa.get = 1'b1;
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b10001) begin
         n_bad++; $display("FAIL rst_pre_arb: got %b want %b", ctlv[0], 5'b10001);
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b01010 || outv[0] !== 8'h5A) begin
         n_bad++; $display("FAIL rst_pre_Z: got %b/%h want %b/%h", ctlv[0], outv[0], 5'b01010, 8'h5A);
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b01010 || outv[0] !== 8'h0A) begin
         n_bad++; $display("FAIL rst_pre_eol: got %b/%h want %b/%h", ctlv[0], outv[0], 5'b01010, 8'h0A);
      end
      @(negedge clock);
      for (int i = 0; i < 7; i++) push(0, 1, hello[i]);
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b10000) begin
         n_bad++; $display("FAIL rst_gap: got %b want %b", ctlv[0], 5'b10000);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (i == 0) begin push(0, 0, 8'h51); push(0, 0, 8'h0A); end
         #1;
         n_cmp++;
         if (ctlv[0] !== 5'b01101 || outv[0] !== hello[i]) begin
            n_bad++; $display("FAIL rst_msg i=%0d: got %b/%h want %b/%h", i, ctlv[0], outv[0], 5'b01101, hello[i]);
         end
      end
      @(negedge clock);
      reset = 1'b1;
      ifa.get = 1'b0;
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b01001) begin
         n_bad++; $display("FAIL rst_assert: got %b want %b", ctlv[0], 5'b01001);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b10000) begin
         n_bad++; $display("FAIL rst_after: got %b want %b", ctlv[0], 5'b10000);
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if (ctlv[0] !== 5'b01000 || outv[0] !== 8'h51) begin
         n_bad++; $display("FAIL rst_regrant: got %b/%h want %b/%h", ctlv[0], outv[0], 5'b01000, 8'h51);
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      reset     = 1'b1;
      model_clr = 1'b1;
      ifa.get   = 1'b0;
      ifb.get   = 1'b0;
      ifc.get   = 1'b0;
      hello     = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
      for (int d = 0; d < 3; d++)
         for (int s = 0; s < 2; s++) begin
            wp[d][s] = '0;
            for (int i = 0; i < 64; i++) mem[d][s][i] = 8'h00;
         end

      test_reset();
      test_message();
      test_round_robin();
      test_timeout();
      test_burst_cap();
      test_lock_eol_off();
      test_reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
